// File: rtl/input_event_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_event_debouncer
// Description : Debounces an already-synchronized 1-bit level with a
//               stability counter. Emits the clean level plus one-cycle
//               rise/fall pulses, and accumulates debounced rising events
//               into reports handed out over a valid/ready handshake.
//               A sticky overflow flag records any accumulator carry.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEBOUNCE_CYCLES : consecutive equal samples to accept a change (2..255)
//   CNT_W           : width of the event accumulator and evt_count
// Ports:
//   clk        in   clock, all logic on posedge
//   reset      in   asynchronous active-high reset
//   input_a    in   synchronized level from the upstream buffer stage
//   level_out  out  debounced level
//   rise_pulse out  one-cycle pulse on debounced 0->1
//   fall_pulse out  one-cycle pulse on debounced 1->0
//   evt_count  out  rise events in the current report
//   evt_valid  out  evt_count holds a report
//   evt_ready  in   consumer accepts report when evt_valid && evt_ready
//   overflow   out  sticky, set on any accumulator carry; reset clears it
// Build option:
//   EVENT_SATURATE_EN : when defined, counts saturate at 2^CNT_W-1
//                       instead of wrapping modulo 2^CNT_W.
// ============================================================================
module input_event_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_a,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] evt_count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  // The first differing sample already counts as one, so the change is
  // accepted when the counter has reached DEBOUNCE_CYCLES-1 and the next
  // sample still agrees.
  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [7:0]       stab_cnt;
  logic [CNT_W-1:0] acc;
  logic             acc_pend;

  logic             slot_free;
  logic             pend;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] sum_lim;

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE_LOW;
      stab_cnt   <= 8'd0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (input_a) begin
            state    <= CHECK_HIGH;
            stab_cnt <= 8'd1;
          end
        end
        CHECK_HIGH: begin
          if (!input_a) begin
            // Glitch: fall back silently, count restarts on next change.
            state    <= IDLE_LOW;
            stab_cnt <= 8'd0;
          end else if (stab_cnt == LAST_CNT) begin
            state      <= IDLE_HIGH;
            stab_cnt   <= 8'd0;
            level_out  <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + 8'd1;
          end
        end
        IDLE_HIGH: begin
          if (!input_a) begin
            state    <= CHECK_LOW;
            stab_cnt <= 8'd1;
          end
        end
        CHECK_LOW: begin
          if (input_a) begin
            state    <= IDLE_HIGH;
            stab_cnt <= 8'd0;
          end else if (stab_cnt == LAST_CNT) begin
            state      <= IDLE_LOW;
            stab_cnt   <= 8'd0;
            level_out  <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE_LOW;
          stab_cnt <= 8'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Event accumulation and report handshake
  // --------------------------------------------------------------------------
  always_comb begin
    slot_free = !evt_valid || evt_ready;
    pend      = acc_pend || rise_pulse;
    // One extra bit so the carry out of the accumulator is visible.
    sum       = {1'b0, acc} + {{CNT_W{1'b0}}, rise_pulse};
`ifdef EVENT_SATURATE_EN
    sum_lim   = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`else
    sum_lim   = sum[CNT_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_count <= '0;
      evt_valid <= 1'b0;
      acc       <= '0;
      acc_pend  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (sum[CNT_W]) begin
        overflow <= 1'b1;
      end
      if (slot_free) begin
        if (pend) begin
          // A rise landing on the handshake edge joins the new report.
          evt_count <= sum_lim;
          evt_valid <= 1'b1;
          acc       <= '0;
          acc_pend  <= 1'b0;
        end else begin
          evt_valid <= 1'b0;
        end
      end else begin
        // Report held by the consumer: keep accumulating behind it.
        // acc_pend distinguishes "wrapped to zero" from "no events".
        acc      <= sum_lim;
        acc_pend <= pend;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_event_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_event_debouncer
// Description : Scoreboard bench for input_event_debouncer (N=4, CNT_W=4).
//               Stimulus pushes expected pulses (kind + cycle) and expected
//               report counts into queues; a monitor pops and compares them
//               whenever the DUT presents a pulse or a handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_event_debouncer;

  localparam int N  = 4;
  localparam int CW = 4;

`ifdef EVENT_SATURATE_EN
  localparam logic [CW-1:0] WRAP_EXP = 4'd15;
`else
  localparam logic [CW-1:0] WRAP_EXP = 4'd0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          input_a;
  logic          level_out;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] evt_count;
  logic          evt_valid;
  logic          evt_ready;
  logic          overflow;

  input_event_debouncer #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .input_a    (input_a),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .evt_count  (evt_count),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_rise;
    int cyc;
  } pulse_t;

  pulse_t        pulse_q[$];
  logic [CW-1:0] rep_q[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: runs at negedge, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL pulse_overlap: rise and fall both high (cycle %0d)", cyc);
      end
      if (rise_pulse === 1'b1 || fall_pulse === 1'b1) begin
        if (pulse_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: rise=%0b fall=%0b expected none (cycle %0d)",
                   rise_pulse, fall_pulse, cyc);
        end else begin
          pulse_t e;
          e = pulse_q.pop_front();
          check("pulse_kind_rise", {31'd0, rise_pulse}, {31'd0, e.is_rise});
          check("pulse_cycle", cyc, e.cyc);
        end
      end
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        if (rep_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_report: count=%0d expected none (cycle %0d)", evt_count, cyc);
        end else begin
          logic [CW-1:0] r;
          r = rep_q.pop_front();
          check("report_count", {28'd0, evt_count}, {28'd0, r});
        end
      end
    end
  end

  // All stimulus steps end 1 time unit after a posedge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_level(input logic v);
    input_a = v;
    pulse_q.push_back('{is_rise: v, cyc: cyc + N});
  endtask

  // One full debounced rise and fall with evt_ready held low.
  task automatic pulse_cycle();
    go_level(1'b1);
    step(N + 1);
    go_level(1'b0);
    step(N + 1);
  endtask

  initial begin
    reset     = 1'b1;
    input_a   = 1'b0;
    evt_ready = 1'b0;
    step(2);
    check("rst_level", level_out, 0);
    check("rst_rise", rise_pulse, 0);
    check("rst_fall", fall_pulse, 0);
    check("rst_count", evt_count, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    step(1);

    // First debounced rise and its report.
    go_level(1'b1);
    step(N - 1);
    check("rise_not_early", level_out, 0);
    step(1);
    check("rise_level", level_out, 1);
    check("rise_pulse_on", rise_pulse, 1);
    check("valid_not_early", evt_valid, 0);
    step(1);
    check("rise_pulse_off", rise_pulse, 0);
    check("first_valid", evt_valid, 1);
    check("first_count", evt_count, 1);
    rep_q.push_back(4'd1);

    // Debounced fall; report untouched.
    go_level(1'b0);
    step(N - 1);
    check("fall_not_early", level_out, 1);
    step(1);
    check("fall_level", level_out, 0);
    check("fall_pulse_on", fall_pulse, 1);
    step(1);
    check("fall_pulse_off", fall_pulse, 0);
    check("fall_count_held", evt_count, 1);

    // Glitch: N-1 high samples then low -> nothing.
    input_a = 1'b1;
    step(N - 1);
    input_a = 1'b0;
    step(N + 1);
    check("glitch_level", level_out, 0);
    check("glitch_valid", evt_valid, 1);
    check("glitch_count", evt_count, 1);

    // Two more rises behind the held report, then one handshake.
    pulse_cycle();
    pulse_cycle();
    check("held_count", evt_count, 1);
    check("held_valid", evt_valid, 1);
    evt_ready = 1'b1;
    rep_q.push_back(4'd2);
    step(1);
    evt_ready = 1'b0;
    check("hs_valid", evt_valid, 1);
    check("hs_count", evt_count, 2);

    // Two rises accumulate, third lands on the handshake edge.
    pulse_cycle();
    pulse_cycle();
    go_level(1'b1);
    step(N);
    evt_ready = 1'b1;
    rep_q.push_back(4'd3);
    step(1);
    evt_ready = 1'b0;
    check("b2b_valid", evt_valid, 1);
    check("b2b_count", evt_count, 3);
    go_level(1'b0);
    step(N + 1);

    // Accumulator wrap / saturate with the report held.
    for (int i = 0; i < 15; i++) pulse_cycle();
    check("pre_wrap_overflow", overflow, 0);
    check("pre_wrap_count", evt_count, 3);
    pulse_cycle();
    check("wrap_overflow", overflow, 1);
    evt_ready = 1'b1;
    rep_q.push_back(WRAP_EXP);
    step(1);
    check("wrap_valid", evt_valid, 1);
    check("wrap_count", evt_count, WRAP_EXP);
    step(1);
    evt_ready = 1'b0;
    check("drained_valid", evt_valid, 0);
    check("sticky_overflow", overflow, 1);

    // Asynchronous reset in CHECK_HIGH with stab_cnt=2.
    input_a = 1'b1;
    step(2);
    #2;
    reset = 1'b1;
    #1;
    check("async_overflow", overflow, 0);
    check("async_level", level_out, 0);
    check("async_valid", evt_valid, 0);
    check("async_count", evt_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pulse_q.push_back('{is_rise: 1'b1, cyc: cyc + N});
    step(N - 1);
    check("post_rst_not_early", level_out, 0);
    step(1);
    check("post_rst_level", level_out, 1);
    check("post_rst_rise", rise_pulse, 1);
    step(1);
    check("post_rst_valid", evt_valid, 1);
    check("post_rst_count", evt_count, 1);
    evt_ready = 1'b1;
    rep_q.push_back(4'd1);
    step(1);
    evt_ready = 1'b0;
    step(2);
    check("final_valid", evt_valid, 0);
    check("pulse_q_empty", pulse_q.size(), 0);
    check("rep_q_empty", rep_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_event_debouncer.md
Name: input_event_debouncer

Overview:
- Downstream consumer of the synchronized-reset input buffer stage. Takes its already-synchronized 1-bit level (`input_a`) and debounces it with a stability counter.
- Emits the clean level plus single-cycle rise/fall pulses.
- Counts debounced rising events and hands accumulated counts to a consumer over a valid/ready handshake, with a sticky overflow flag.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive identical samples needed to accept a level change; legal range 2..255.
- CNT_W, 8, width of event accumulator and of evt_count.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset; all state cleared immediately on assertion.
- input_a  input  1  synchronized level from upstream buffer stage.
- level_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse on debounced 0->1.
- fall_pulse  output  1  one-cycle pulse on debounced 1->0.
- evt_count  output  CNT_W  number of rise events in the current report.
- evt_valid  output  1  evt_count holds a report.
- evt_ready  input  1  consumer accepts the report when evt_valid && evt_ready at posedge.
- overflow  output  1  sticky; set when the accumulator exceeds 2^CNT_W-1. Cleared only by reset.

Behaviour:
- Reset values:
  - level_out=0, rise_pulse=0, fall_pulse=0, evt_count=0, evt_valid=0, overflow=0.
  - FSM=IDLE_LOW, stab_cnt=0, acc=0, acc_pend=0.
- FSM states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW. stab_cnt is 8 bits.
  - IDLE_LOW: if input_a=1, go to CHECK_HIGH with stab_cnt=1; else stay.
  - CHECK_HIGH:
    - input_a=0: go to IDLE_LOW, stab_cnt=0.
    - input_a=1 and stab_cnt==DEBOUNCE_CYCLES-1: go to IDLE_HIGH, level_out<=1, rise_pulse<=1.
    - otherwise stab_cnt++.
  - IDLE_HIGH / CHECK_LOW: mirror image of the above; the transition to IDLE_LOW sets level_out<=0 and fall_pulse<=1.
- Latency: the first of N=DEBOUNCE_CYCLES consecutive equal samples is taken at edge k. level_out and the pulse are visible after edge k+N-1.
- Glitch rule: any differing sample in CHECK_* returns to the prior IDLE_* state with no pulse. The count restarts on the next differing sample.
- Pulses are high for exactly one cycle. rise_pulse and fall_pulse are never high together.
- Event path (rise = registered rise_pulse):
  - slot_free = !evt_valid || evt_ready.
  - sum = acc + rise, computed in CNT_W+1 bits. pend = acc_pend || rise.
  - If slot_free && pend: evt_count<=lim(sum), evt_valid<=1, acc<=0, acc_pend<=0.
  - Else if slot_free && !pend: evt_valid<=0.
  - Else (slot full): acc<=lim(sum), acc_pend<=pend.
  - lim(): wraps modulo 2^CNT_W (default build). Any carry sets overflow<=1.
- evt_valid-to-report latency: evt_valid is high after edge k+N when the slot is free.
- A report with evt_count=0 is legal after a wrap; evt_valid still asserts because events occurred.
- Handshake rules:
  - evt_count and evt_valid hold stable while evt_valid && !evt_ready.
  - A handshake and a new rise on the same edge carry that rise into the newly loaded report (back-to-back reports, no bubble).
- evt_ready is ignored while evt_valid=0.
- Reset mid-operation: outputs and state return to reset values asynchronously. After release:
  - no pulses until N fresh samples are taken;
  - input_a already high at release produces one rise event after N samples.

Optional Feature:
- Macro EVENT_SATURATE_EN.
  - Defined: lim() saturates at 2^CNT_W-1 instead of wrapping, in both the acc and evt_count paths. overflow is still set on the first saturating carry.
  - Undefined: modulo wrap as described above.

Test Plan:
(DEBOUNCE_CYCLES=4, CNT_W=4 unless stated)
- Reset, input_a=1 from edge 1, evt_ready=0 -> level_out=1 and rise_pulse=1 for one cycle after edge 4; evt_valid=1, evt_count=1 after edge 5.
- input_a high for 3 samples then low -> level_out stays 0, no rise_pulse/fall_pulse, evt_valid stays 0.
- Debounced high then input_a=0 for 4 samples -> fall_pulse for one cycle, level_out=0, evt_count unchanged.
- evt_ready=0, 3 debounced rises -> evt_count holds 1 (acc=2); evt_ready=1 for one cycle -> next cycle evt_valid=1, evt_count=2; a rise on the handshake edge yields evt_count=3.
- evt_ready=0, report 1 held, 16 more rises -> acc wraps to 0, overflow=1; releasing evt_ready gives evt_valid=1, evt_count=0. With EVENT_SATURATE_EN: evt_count=15, overflow=1.
- reset pulsed mid CHECK_HIGH (stab_cnt=2) -> all outputs 0 immediately; after release, level_out rises only after 4 new consecutive high samples.
